// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty flags,
// sticky overflow/underflow errors and selectable standard or first-word-fall-through read.
module sync_fifo_flags #(
  parameter int DSIZE      = 8,
  parameter int ASIZE      = 4,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 2,
  parameter int FWFT       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  input  logic             clr_err,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] C_DEPTH  = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] C_AFULL  = (ASIZE+1)'(AFULL_LVL);
  localparam logic [ASIZE:0] C_AEMPTY = (ASIZE+1)'(AEMPTY_LVL);

  logic [DSIZE-1:0] r_mem [DEPTH];
  logic [ASIZE-1:0] r_wptr;
  logic [ASIZE-1:0] r_rptr;
  logic [ASIZE:0]   r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;
  logic w_wr_rej;
  logic w_rd_rej;

  // Flags come only from the registered count, so winc/rinc never reach them combinationally.
  assign w_full   = (r_count == C_DEPTH);
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = winc && !w_full;
  assign w_rd_acc = rinc && !w_empty;
  assign w_wr_rej = winc && w_full;
  assign w_rd_rej = rinc && w_empty;

  assign wfull         = w_full;
  assign rempty        = w_empty;
  assign walmost_full  = (r_count >= C_AFULL);
  assign ralmost_empty = (r_count <= C_AEMPTY);
  assign count         = r_count;
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + ASIZE'(1);
      end
      if (w_rd_acc) begin
        r_rptr <= r_rptr + ASIZE'(1);
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + (ASIZE+1)'(1);
        2'b01:   r_count <= r_count - (ASIZE+1)'(1);
        default: r_count <= r_count;
      endcase
      // A new error in the same cycle as clr_err keeps the flag set.
      r_overflow  <= w_wr_rej || (r_overflow  && !clr_err);
      r_underflow <= w_rd_rej || (r_underflow && !clr_err);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata = r_mem[r_rptr];
    end else begin : g_std
      logic [DSIZE-1:0] r_rdata;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_rdata <= '0;
        end else if (w_rd_acc) begin
          r_rdata <= r_mem[r_rptr];
        end
      end
      assign rdata = r_rdata;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Drives a standard-read and an FWFT instance with identical random/directed traffic
// and compares both against a queue-based model of the FIFO.
module tb_sync_fifo_flags;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wdata = '0;
  logic       winc = 1'b0;
  logic       rinc = 1'b0;
  logic       clr_err = 1'b0;

  logic [7:0] rdata_s, rdata_f;
  logic       wfull_s, rempty_s, afull_s, aempty_s, ovf_s, udf_s;
  logic       wfull_f, rempty_f, afull_f, aempty_f, ovf_f, udf_f;
  logic [4:0] count_s, count_f;

  int checks = 0;
  int failures = 0;

  // Reference model state
  byte unsigned q[$];
  logic [7:0]   m_rdata;
  logic         m_ovf;
  logic         m_udf;
  bit           ff_seen;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DSIZE(8), .ASIZE(4), .AFULL_LVL(12), .AEMPTY_LVL(2), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .rinc(rinc), .clr_err(clr_err),
    .rdata(rdata_s), .wfull(wfull_s), .rempty(rempty_s), .walmost_full(afull_s),
    .ralmost_empty(aempty_s), .count(count_s), .overflow(ovf_s), .underflow(udf_s));

  sync_fifo_flags #(.DSIZE(8), .ASIZE(4), .AFULL_LVL(12), .AEMPTY_LVL(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .rinc(rinc), .clr_err(clr_err),
    .rdata(rdata_f), .wfull(wfull_f), .rempty(rempty_f), .walmost_full(afull_f),
    .ralmost_empty(aempty_f), .count(count_f), .overflow(ovf_f), .underflow(udf_f));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string ctx);
    int n;
    n = q.size();
    check_eq({ctx, ":count_s"},  32'(count_s),  32'(n));
    check_eq({ctx, ":count_f"},  32'(count_f),  32'(n));
    check_eq({ctx, ":wfull_s"},  32'(wfull_s),  32'(n == DEPTH));
    check_eq({ctx, ":wfull_f"},  32'(wfull_f),  32'(n == DEPTH));
    check_eq({ctx, ":rempty_s"}, 32'(rempty_s), 32'(n == 0));
    check_eq({ctx, ":rempty_f"}, 32'(rempty_f), 32'(n == 0));
    check_eq({ctx, ":afull_s"},  32'(afull_s),  32'(n >= 12));
    check_eq({ctx, ":afull_f"},  32'(afull_f),  32'(n >= 12));
    check_eq({ctx, ":aempty_s"}, 32'(aempty_s), 32'(n <= 2));
    check_eq({ctx, ":aempty_f"}, 32'(aempty_f), 32'(n <= 2));
    check_eq({ctx, ":ovf_s"},    32'(ovf_s),    32'(m_ovf));
    check_eq({ctx, ":ovf_f"},    32'(ovf_f),    32'(m_ovf));
    check_eq({ctx, ":udf_s"},    32'(udf_s),    32'(m_udf));
    check_eq({ctx, ":udf_f"},    32'(udf_f),    32'(m_udf));
    check_eq({ctx, ":rdata_s"},  32'(rdata_s),  32'(m_rdata));
    if (n != 0) check_eq({ctx, ":rdata_f"}, 32'(rdata_f), 32'(q[0]));
  endtask

  // One clock cycle: drive inputs, let the edge happen, update model, check outputs.
  task automatic step(input string ctx, input bit w, input logic [7:0] d, input bit r, input bit c);
    bit full, empty, wacc, racc;
    winc = w; wdata = d; rinc = r; clr_err = c;
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    wacc  = w && !full;
    racc  = r && !empty;
    @(posedge clk);
    if (racc) begin
      m_rdata = q.pop_front();
      if (m_rdata == 8'hFF && ff_seen) check_eq({ctx, ":dropped_ff_read"}, 32'(m_rdata), 32'h0);
    end
    if (wacc) q.push_back(d);
    m_ovf = (w && full)  || (m_ovf && !c);
    m_udf = (r && empty) || (m_udf && !c);
    #1;
    $display("%s w=%0d d=%02h r=%0d clr=%0d -> count=%0d rdata_s=%02h rdata_f=%02h ovf=%0d udf=%0d",
             ctx, w, d, r, c, count_s, rdata_s, rdata_f, ovf_s, udf_s);
    check_all(ctx);
    winc = 1'b0; rinc = 1'b0; clr_err = 1'b0;
  endtask

  task automatic model_reset();
    q.delete();
    m_rdata = '0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  initial begin
    model_reset();
    ff_seen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    for (int i = 0; i < 16; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    step("ovf", 1'b1, 8'hFF, 1'b0, 1'b0);
    step("ovf_clr_set", 1'b1, 8'hFF, 1'b0, 1'b1);
    step("ovf_clr", 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    step("udf", 1'b0, 8'h00, 1'b1, 1'b0);
    step("udf_clr", 1'b0, 8'h00, 1'b0, 1'b1);

    step("fwft_wr", 1'b1, 8'hA5, 1'b0, 1'b0);
    step("fwft_pop", 1'b0, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) step("pre8", 1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step("wrap", 1'b1, 8'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step("drain8", 1'b0, 8'h00, 1'b1, 1'b0);
    step("rw_empty", 1'b1, 8'h5A, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step("tofull", 1'b1, 8'($urandom_range(0, 254)), 1'b0, 1'b0);
    step("rw_full", 1'b1, 8'hFF, 1'b1, 1'b0);
    ff_seen = 1'b1;
    for (int i = 0; i < 16; i++) step("drain_ff", 1'b0, 8'h00, 1'b1, 1'b0);
    ff_seen = 1'b0;
    step("clr", 1'b0, 8'h00, 1'b0, 1'b1);

    for (int i = 0; i < 400; i++) begin
      int wp, rp;
      wp = (i < 200) ? 70 : 35;
      rp = (i < 200) ? 35 : 70;
      step("rand", ($urandom_range(0, 99) < wp), 8'($urandom), ($urandom_range(0, 99) < rp),
           ($urandom_range(0, 99) < 8));
    end

    while (q.size() > 5) step("to5", 1'b0, 8'h00, 1'b1, 1'b0);
    while (q.size() < 5) step("to5", 1'b1, 8'($urandom), 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("post_wr", 1'b1, 8'h3C, 1'b0, 1'b0);
    step("post_rd", 1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("post_rd_val", 32'(rdata_s), 32'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
